// File: rtl/alu_muldiv_sequencer_if.sv
// Handshake and ALU-sharing bundle between the main control FSM / datapath and
// the multiply/divide sequencer.
// master: main FSM + datapath (drives start/op/operands and the ALU result).
// slave:  alu_muldiv_sequencer (drives status, HI/LO and the ALU request/operands).
interface alu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic             alu_req;
  logic [5:0]       alu_control;
  logic [WIDTH-1:0] alu_src0;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output start, op, rs_val, rt_val, alu_result,
    input  busy, done, hi, lo, div_zero, alu_req, alu_control, alu_src0, alu_src1
  );

  modport slave (
    input  start, op, rs_val, rt_val, alu_result,
    output busy, done, hi, lo, div_zero, alu_req, alu_control, alu_src0, alu_src1
  );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer that time-shares the datapath's 32-bit ALU and
// accumulates HI/LO locally. Latency: done 37 cycles after accept (mult), 69 (div).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Ports: clk, rst_n (async active-low), bus (alu_muldiv_sequencer_if.slave):
//   start/op/rs_val/rt_val request, busy/done/hi/lo/div_zero status and results,
//   alu_req/alu_control/alu_src0/alu_src1 ALU drive, alu_result combinational ALU return.
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide by zero short-circuits to
// DONE in one cycle with hi = rs_val, lo = all ones, div_zero = 1.
module alu_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_muldiv_sequencer_if.slave  bus
);

  localparam logic [5:0] ALUOP_ADDU = 6'h21;
  localparam logic [5:0] ALUOP_SUBU = 6'h23;
  localparam logic [5:0] ALUOP_NOR  = 6'h27;
  localparam logic [5:0] ALUOP_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_MUL_ADD, S_DIV_CMP, S_DIV_SUB, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t           state;
  logic             is_div;      // latched op[1]
  logic             sa, sb;      // operand signs (only for signed ops)
  logic [5:0]       cnt;
  logic [WIDTH-1:0] a_q, b_q;    // raw operands, then magnitudes after NEG_A/NEG_B
  logic [WIDTH-1:0] acc_hi;      // product high half, or remainder R
  logic [WIDTH-1:0] acc_lo;      // product low half / multiplier, or quotient Q
  logic [WIDTH-1:0] mcand;       // multiplicand, or divisor D
  logic             msb, lt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;
`ifdef MULDIV_DIVZERO_FAST_EN
  logic             div_zero_q;
`endif

  logic             alu_req;
  logic [5:0]       alu_control;
  logic [WIDTH-1:0] alu_src0, alu_src1;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [WIDTH-1:0] mag_b;
  logic             lo_neg, hi_neg, take;

  assign res    = bus.alu_result;
  assign lo_neg = sa ^ sb;
  // Remainder follows the dividend's sign; product high half follows the product sign.
  assign hi_neg = is_div ? sa : (sa ^ sb);
  assign mag_b  = sb ? res : b_q;
  // Carry out of the ALU add, reconstructed from operand and sum MSBs.
  assign carry  = (acc_hi[WIDTH-1] & alu_src1[WIDTH-1]) |
                  ((acc_hi[WIDTH-1] | alu_src1[WIDTH-1]) & ~res[WIDTH-1]);
  // Restoring step succeeds when the shifted-out bit makes R >= 2^32 or R >= D.
  assign take   = msb | ~lt;

  // ALU drive is a pure decode of registered state, so it is stable all cycle.
  always_comb begin
    alu_req     = 1'b0;
    alu_control = '0;
    alu_src0    = '0;
    alu_src1    = '0;
    case (state)
      S_NEG_A: begin
        alu_req = 1'b1; alu_control = ALUOP_SUBU; alu_src1 = a_q;
      end
      S_NEG_B: begin
        alu_req = 1'b1; alu_control = ALUOP_SUBU; alu_src1 = b_q;
      end
      S_MUL_ADD: begin
        alu_req = 1'b1; alu_control = ALUOP_ADDU; alu_src0 = acc_hi;
        alu_src1 = acc_lo[0] ? mcand : '0;
      end
      S_DIV_CMP: begin
        alu_req = 1'b1; alu_control = ALUOP_SLTU;
        alu_src0 = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]}; alu_src1 = mcand;
      end
      S_DIV_SUB: begin
        alu_req = 1'b1; alu_control = ALUOP_SUBU; alu_src0 = acc_hi; alu_src1 = mcand;
      end
      S_FIX_LO: begin
        alu_req = 1'b1; alu_control = ALUOP_SUBU; alu_src1 = acc_lo;
      end
      S_FIX_HI: begin
        alu_req = 1'b1;
        // 64-bit negate: when the low half is non-zero no borrow reaches HI,
        // so HI becomes ~HI. acc_lo may already be negated; zero-ness is preserved.
        if (!is_div && acc_lo != '0) begin
          alu_control = ALUOP_NOR; alu_src0 = acc_hi;
        end else begin
          alu_control = ALUOP_SUBU; alu_src1 = acc_hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      msb    <= 1'b0;
      lt     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            a_q    <= bus.rs_val;
            b_q    <= bus.rt_val;
            sa     <= bus.rs_val[WIDTH-1] & ~bus.op[0];
            sb     <= bus.rt_val[WIDTH-1] & ~bus.op[0];
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef MULDIV_DIVZERO_FAST_EN
            div_zero_q <= 1'b0;
            if (bus.op[1] && bus.rt_val == '0) begin
              state      <= S_DONE;
              done_q     <= 1'b1;
              hi_q       <= bus.rs_val;
              lo_q       <= '1;
              div_zero_q <= 1'b1;
            end else begin
              state <= S_NEG_A;
            end
`else
            state <= S_NEG_A;
`endif
          end
        end
        S_NEG_A: begin
          a_q   <= sa ? res : a_q;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          b_q    <= mag_b;
          acc_hi <= '0;
          if (is_div) begin
            acc_lo <= a_q;
            mcand  <= mag_b;
            state  <= S_DIV_CMP;
          end else begin
            acc_lo <= mag_b;
            mcand  <= a_q;
            state  <= S_MUL_ADD;
          end
        end
        S_MUL_ADD: begin
          acc_hi <= {carry, res[WIDTH-1:1]};
          acc_lo <= {res[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_FIX_LO;
        end
        S_DIV_CMP: begin
          msb    <= acc_hi[WIDTH-1];
          acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          lt     <= res[0];
          state  <= S_DIV_SUB;
        end
        S_DIV_SUB: begin
          if (take) acc_hi <= res;
          acc_lo <= {acc_lo[WIDTH-1:1], take};
          cnt    <= cnt + 6'd1;
          state  <= (cnt == 6'd31) ? S_FIX_LO : S_DIV_CMP;
        end
        S_FIX_LO: begin
          if (lo_neg) acc_lo <= res;
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          hi_q   <= hi_neg ? res : acc_hi;
          lo_q   <= acc_lo;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
`ifdef MULDIV_DIVZERO_FAST_EN
  assign bus.div_zero    = div_zero_q;
`else
  assign bus.div_zero    = 1'b0;
`endif
  assign bus.alu_req     = alu_req;
  assign bus.alu_control = alu_control;
  assign bus.alu_src0    = alu_src0;
  assign bus.alu_src1    = alu_src1;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: directed MULT/DIV runs with a
// result scoreboard, a behavioural datapath ALU, per-cycle opcode checks,
// ignored-start and mid-operation reset cases.
module tb_alu_muldiv_sequencer;

  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLTU = 6'h2B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_sequencer_if bus ();

  alu_muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural datapath ALU.
  always_comb begin
    case (bus.alu_control)
      OP_ADDU: bus.alu_result = bus.alu_src0 + bus.alu_src1;
      OP_SUBU: bus.alu_result = bus.alu_src0 - bus.alu_src1;
      OP_SLTU: bus.alu_result = {31'b0, (bus.alu_src0 < bus.alu_src1)};
      OP_NOR:  bus.alu_result = ~(bus.alu_src0 | bus.alu_src1);
      default: bus.alu_result = 32'h0;
    endcase
  end

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    logic        fixhi_sub;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    logic signed [31:0] as_, bs_;
    e.dz = 1'b0;
    e.fixhi_sub = 1'b0;
    as_ = a;
    bs_ = b;
    if (!op[1]) begin
      if (!op[0]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else        p = {32'h0, a} * {32'h0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = 37;
      e.fixhi_sub = (p[31:0] == 32'h0);
    end else begin
      e.lat = 69;
      if (b == 32'h0) begin
`ifdef MULDIV_DIVZERO_FAST_EN
        e.lat = 1;
        e.hi  = a;
        e.lo  = 32'hFFFF_FFFF;
        e.dz  = 1'b1;
`else
        e.hi = a;
        e.lo = (!op[0] && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
`endif
      end else if (op[0]) begin
        e.lo = a / b;
        e.hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000;
        e.hi = 32'h0;
      end else begin
        e.lo = as_ / bs_;
        e.hi = as_ % bs_;
      end
    end
    return e;
  endfunction

  function automatic logic [5:0] exp_op(input logic [1:0] op, input int cyc, input logic fixhi_sub);
    int last;
    last = op[1] ? 69 : 37;
    if (cyc <= 2)              return OP_SUBU;
    else if (cyc == last - 2)  return OP_SUBU;
    else if (cyc == last - 1)  return (op[1] || fixhi_sub) ? OP_SUBU : OP_NOR;
    else if (!op[1])           return OP_ADDU;
    else                       return (cyc % 2 == 1) ? OP_SLTU : OP_SUBU;
  endfunction

  // ALU drive must be all-zero whenever the block does not own the ALU.
  always @(negedge clk) begin
    if (rst_n && !bus.alu_req)
      check("alu_idle_zero", bus.alu_control | bus.alu_src0 | bus.alu_src1, 32'h0);
  end

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int poke_cycle, input int abort_cycle);
    exp_t e, got_e;
    int   cyc;
    logic got;
    e = model(op, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'($urandom_range(0, 3));
    bus.rs_val = $urandom; bus.rt_val = $urandom;
    cyc = 1;
    got = 1'b0;
    while (cyc <= 200 && !got) begin
      if (cyc == poke_cycle) begin
        bus.start = 1'b1; bus.op = 2'd2; bus.rs_val = 32'h1234; bus.rt_val = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (cyc == abort_cycle) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_done", {31'b0, bus.done}, 32'h0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        check("abort_alu_req", {31'b0, bus.alu_req}, 32'h0);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (bus.done) begin
        got = 1'b1;
        got_e = sb_q.pop_front();
        check("done_cycle", cyc, got_e.lat);
        check("hi", bus.hi, got_e.hi);
        check("lo", bus.lo, got_e.lo);
        check("div_zero", {31'b0, bus.div_zero}, {31'b0, got_e.dz});
        check("busy_at_done", {31'b0, bus.busy}, 32'h1);
      end else begin
        check("busy", {31'b0, bus.busy}, 32'h1);
        check("alu_req", {31'b0, bus.alu_req}, 32'h1);
        check("alu_op", {26'b0, bus.alu_control}, {26'b0, exp_op(op, cyc, e.fixhi_sub)});
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", {31'b0, got}, 32'h1);
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_done", {31'b0, bus.busy}, 32'h0);
    check("done_pulse_end", {31'b0, bus.done}, 32'h0);
    check("hi_hold", bus.hi, e.hi);
    check("lo_hold", bus.lo, e.lo);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.rs_val = 32'h0;
    bus.rt_val = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_div_zero", {31'b0, bus.div_zero}, 32'h0);
    check("rst_alu_req", {31'b0, bus.alu_req}, 32'h0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_alu", bus.alu_control | bus.alu_src0 | bus.alu_src1, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);   // MULTU max
    run(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);           // MULT -3 * 5
    run(2'd0, 32'h0, 32'h8000_0000, 0, 0);           // MULT zero, FIX_HI via SUBU
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);           // DIV -7 / 2
    run(2'd3, 32'd100, 32'd7, 0, 0);                 // DIVU 100 / 7
    run(2'd3, 32'd100, 32'd0, 0, 0);                 // DIVU by zero
    run(2'd2, 32'hFFFF_FFFB, 32'd0, 0, 0);           // DIV -5 by zero
    run(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10, 0);  // start ignored mid-run
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);   // DIV overflow case
    run(2'd2, 32'hFFFF_FC18, 32'd7, 0, 20);          // reset mid-DIV
    run(2'd2, 32'hFFFF_FC18, 32'd7, 0, 0);           // fresh DIV after reset
    run(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);   // MULT extremes
    run(2'd2, 32'd17, 32'hFFFF_FFFB, 0, 0);          // DIV 17 / -5
    for (int i = 0; i < 6; i++)
      run(2'($urandom_range(0, 3)), $urandom, $urandom | 32'h1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_sequencer.md
# alu_muldiv_sequencer

Multi-cycle multiply/divide controller for the multi-cycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU by time-sharing the existing combinational 32-bit ALU: it drives the ALU opcode and operands every cycle and accumulates results into local HI/LO registers. It sits beside the main control FSM. The main FSM pulses `start` and waits for `done`. While `alu_req` is high, the datapath ALU input mux selects this block's operands.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `op`  in  2  operation code: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `rs_val`  in  32  multiplicand or dividend.
- `rt_val`  in  32  multiplier or divisor.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `hi`  out  32  HI result: product[63:32] or remainder.
- `lo`  out  32  LO result: product[31:0] or quotient.
- `div_zero`  out  1  divide-by-zero flag, valid with `done`.
- `alu_req`  out  1  high when this block owns the ALU.
- `alu_control`  out  6  ALU opcode, using the ALUOP definitions.
- `alu_src0`  out  32  ALU operand 0.
- `alu_src1`  out  32  ALU operand 1.
- `alu_result`  in  32  combinational ALU result, sampled at the end of the same cycle.

## Operation
- States: IDLE, NEG_A, NEG_B, MUL_ADD, DIV_CMP, DIV_SUB, FIX_LO, FIX_HI, DONE.
- IDLE:
  - On `start`, latch `op`, the operands, `sa = rs_val[31] & signed`, `sb = rt_val[31] & signed`, and clear the iteration counter (6 bits).
  - Go to NEG_A. A `start` in any other state is ignored.
- NEG_A / NEG_B: always issued, so latency is fixed.
  - ALU op is SUBU with `0 - operand`.
  - Latch the magnitude: the ALU result if the sign flag is set, otherwise the raw operand.
- Multiply:
  - Setup: `acc_hi = 0`, `acc_lo = |B|`, `mcand = |A|`.
  - MUL_ADD runs 32 cycles. ALU op ADDU with `src0 = acc_hi`, `src1 = acc_lo[0] ? mcand : 0`.
  - Carry is computed locally: `(a31 & b31) | ((a31 | b31) & ~sum31)`.
  - Then `{acc_hi, acc_lo} <= {carry, sum, acc_lo[31:1]}`.
- Divide (restoring):
  - Setup: `R = 0`, `Q = |A|`, `D = |B|`.
  - DIV_CMP:
    - Shift `{R, Q}` left by 1 and keep the outgoing `R[31]` as `msb`.
    - ALU op SLTU with `src0 = R_shifted`, `src1 = D`. Latch `lt = result[0]`.
  - DIV_SUB:
    - ALU op SUBU with `R - D`.
    - If `msb | ~lt`: `R <= result`, `Q[0] <= 1`. Otherwise `Q[0] <= 0`.
  - 32 CMP/SUB pairs.
- FIX_LO / FIX_HI (sign fix):
  - Product sign is `sa ^ sb`. Quotient sign is `sa ^ sb`. Remainder sign is `sa`.
  - Product, FIX_LO: SUBU `0 - lo`.
  - Product, FIX_HI: SUBU `0 - hi` if the original `lo == 0`, otherwise NOR(`hi`, 0).
  - Divide: FIX_LO is SUBU `0 - Q`, FIX_HI is SUBU `0 - R`.
  - A result is replaced only when its sign flag is set.
- `hi`/`lo` update at the end of FIX_HI and hold until the next update.
- DIV of 0x80000000 by -1 gives LO = 0x80000000, HI = 0.
- `alu_req` is high in NEG_A, NEG_B, MUL_ADD, DIV_CMP, DIV_SUB, FIX_LO and FIX_HI.
- When `alu_req` is low, `alu_control`, `alu_src0` and `alu_src1` are 0.
- DONE: `done = 1`, then return to IDLE.

## Timing
- Let the accept cycle be 0.
- MULT/MULTU: NEG_A in cycle 1, NEG_B in 2, MUL_ADD in 3–34, FIX_LO in 35, FIX_HI in 36. `done` is high in cycle 37.
- DIV/DIVU: NEG_A in cycle 1, NEG_B in 2, DIV_CMP/DIV_SUB in 3–66, FIX_LO in 67, FIX_HI in 68. `done` is high in cycle 69.
- `busy` is high from cycle 1 through the DONE cycle inclusive. A new `start` is accepted one cycle after DONE.
- Reset values: `busy`, `done`, `div_zero` and `alu_req` are 0; `hi` and `lo` are 0; ALU outputs are 0; state is IDLE.
- Reset mid-operation aborts immediately with no `done`, and all registers return to their reset values.

## Configuration
- `MULDIV_DIVZERO_FAST_EN` defined:
  - DIV/DIVU with `rt_val == 0` goes IDLE→DONE with `done` in cycle 1.
  - Results: `hi = rs_val` (raw), `lo = 0xFFFFFFFF`, `div_zero = 1`.
- `MULDIV_DIVZERO_FAST_EN` undefined:
  - Divide by zero runs the normal 69-cycle sequence. The algorithm yields `Q = 0xFFFFFFFF` and `R = |A|`, then the normal sign fix applies.
  - `div_zero` is tied to 0.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001, `done` in cycle 37, `busy` low in cycle 38.
- MULT 0xFFFFFFFD (-3) × 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. Also MULT 0 × 0x80000000 → `hi` = `lo` = 0, which exercises the FIX_HI path when `lo == 0`.
- DIV -7 ÷ 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF, `done` in cycle 69. DIVU 100 ÷ 7 → `lo` = 14, `hi` = 2.
- DIVU 100 ÷ 0:
  - With the macro: `done` in cycle 1, `hi` = 100, `lo` = 0xFFFFFFFF, `div_zero` = 1.
  - Without the macro: `done` in cycle 69, `lo` = 0xFFFFFFFF, `hi` = 100.
- `start` pulsed again in cycle 10 of a MULTU → ignored, and the original result is unchanged.
- `rst_n` low in cycle 20 of a DIV → `busy`, `hi` and `lo` read 0 immediately. A fresh DIV then completes correctly.
- Cycle by cycle on every run: `alu_control`/`alu_src0`/`alu_src1` are 0 whenever `alu_req` = 0. A bench ALU model checks the opcode sequence NEG_A → NEG_B → ADDU ×32 or (SLTU, SUBU) ×32 → FIX.
